// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM for a multicycle MIPS datapath. Each instruction is
// sequenced through fetch, decode, execute, memory and writeback. The block
// drives the datapath mux selects and write enables, plus the 2-bit ALUOp
// that feeds the downstream ALU control decoder. FETCH, MEMRD and MEMWR wait
// for the memory-ready handshake before they advance.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   Opcode[5:0]  IR[31:26]; sampled only in DECODE and MEMADR
//   MemReady     memory completes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],
//   PCSource[1:0]  datapath controls (Moore, decoded from the state)
//   IllegalOp    sticky unsupported-opcode flag, cleared only by reset
//   State[3:0]   current state, for debug
//
// Optional feature (macro MC_RETIRE_CNT_EN)
//   Adds RetireCount[31:0]. It counts retired instructions and wraps.
//   Illegal opcodes are not counted.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [31:0]        RetireCount
`endif
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_illegal_hit;
    logic       r_illegal;

    // Raw Moore decode, before the reset gating of the write enables.
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sticky illegal-opcode flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_illegal_hit) begin
            r_illegal <= 1'b1;
        end else begin
            r_illegal <= r_illegal;
        end
    end

    // Next-state logic; Opcode is consulted only in DECODE and MEMADR.
    always_comb begin
        w_next_state  = S_FETCH;
        w_illegal_hit = 1'b0;
        case (r_state)
            S_FETCH:   w_next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE: w_next_state = S_EXEC;
                    OP_LW:    w_next_state = S_MEMADR;
                    OP_SW:    w_next_state = S_MEMADR;
                    OP_BEQ:   w_next_state = S_BRANCH;
                    OP_J:     w_next_state = S_JUMP;
                    OP_ADDI:  w_next_state = S_ADDIEX;
                    default: begin
                        w_next_state  = S_FETCH;
                        w_illegal_hit = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next_state = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next_state = S_FETCH;
            S_MEMWR:   w_next_state = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:    w_next_state = S_RTYPEWB;
            S_RTYPEWB: w_next_state = S_FETCH;
            S_BRANCH:  w_next_state = S_FETCH;
            S_JUMP:    w_next_state = S_FETCH;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            S_ADDIWB:  w_next_state = S_FETCH;
            // Encodings 12-15 are unreachable; recover to FETCH.
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Output decode from the state register (MemReady gates only FETCH).
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        IorD            = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        MemtoReg        = 1'b0;
        RegDst          = 1'b0;
        w_reg_write     = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'b00;
        ALUOp           = 2'b00;
        PCSource        = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                ALUSrcB    = 2'b01;
                w_ir_write = MemReady;
                w_pc_write = MemReady;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                IorD       = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                MemtoReg    = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                IorD        = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RTYPEWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA         = 1'b1;
                ALUOp           = 2'b01;
                w_pc_write_cond = 1'b1;
                PCSource        = 2'b01;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                PCSource   = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            default: begin
                w_pc_write = 1'b0;
            end
        endcase
    end

    // Write enables are forced low combinationally while reset is asserted,
    // so no state element in the datapath is disturbed during reset.
    assign PCWrite     = w_pc_write      & rst_n;
    assign PCWriteCond = w_pc_write_cond & rst_n;
    assign MemRead     = w_mem_read      & rst_n;
    assign MemWrite    = w_mem_write     & rst_n;
    assign IRWrite     = w_ir_write      & rst_n;
    assign RegWrite    = w_reg_write     & rst_n;
    assign IllegalOp   = r_illegal;
    assign State       = r_state;

`ifdef MC_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;
    logic        w_retire;

    // An instruction retires on the edge that leaves its last state.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB:   w_retire = 1'b1;
            S_MEMWR:   w_retire = MemReady;
            S_RTYPEWB: w_retire = 1'b1;
            S_BRANCH:  w_retire = 1'b1;
            S_JUMP:    w_retire = 1'b1;
            S_ADDIWB:  w_retire = 1'b1;
            default:   w_retire = 1'b0;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= 32'd0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end else begin
            r_retire_cnt <= r_retire_cnt;
        end
    end

    assign RetireCount = r_retire_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       IllegalOp;
    logic [3:0] State;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] RetireCount;
`endif

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
`ifdef MC_RETIRE_CNT_EN
        , .RetireCount(RetireCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctl_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the current step, the steps still to run for the
    // instruction in flight, the sticky flag and the retire count.
    int          m_state;
    int          m_todo[$];
    bit          m_illegal;
    logic [31:0] m_retire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What each step of an instruction must drive onto the datapath.
    function automatic ctl_t expect_ctl(input int st, input bit mr, input bit in_reset);
        ctl_t c;
        c = '0;
        if (st == 0) begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
        if (st == 1) c.alu_src_b = 2'b11;
        if (st == 2 || st == 10) begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
        if (st == 3) begin c.mem_read = 1'b1; c.iord = 1'b1; end
        if (st == 4) begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
        if (st == 5) begin c.mem_write = 1'b1; c.iord = 1'b1; end
        if (st == 6) begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
        if (st == 7) begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
        if (st == 8) begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
        if (st == 9) begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
        if (st == 11) c.reg_write = 1'b1;
        if (in_reset) begin
            c.pc_write = 1'b0; c.pc_write_cond = 1'b0; c.ir_write = 1'b0;
            c.mem_write = 1'b0; c.mem_read = 1'b0; c.reg_write = 1'b0;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_todo.delete();
        m_illegal = 1'b0;
        m_retire  = 32'd0;
    endtask

    // Advance the model by one clock edge given the inputs of that cycle.
    task automatic model_edge(input logic [5:0] op, input bit mr);
        bit waits;
        waits = (m_state == 0 || m_state == 3 || m_state == 5) && !mr;
        if (waits) return;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_todo.delete();
            if (op == 6'b000000) m_todo = '{6, 7};
            else if (op == 6'b100011 || op == 6'b101011) m_todo = '{2};
            else if (op == 6'b000100) m_todo = '{8};
            else if (op == 6'b000010) m_todo = '{9};
            else if (op == 6'b001000) m_todo = '{10, 11};
            else m_illegal = 1'b1;
            m_state = (m_todo.size() == 0) ? 0 : m_todo.pop_front();
        end else begin
            if (m_state == 2) m_todo = (op == 6'b100011) ? '{3, 4} : '{5};
            if (m_todo.size() == 0) begin
                m_state  = 0;
                m_retire = m_retire + 32'd1;
            end else begin
                m_state = m_todo.pop_front();
            end
        end
    endtask

    // One cycle: drive on the falling edge, compare, then step the model.
    task automatic cyc(input logic [5:0] op, input bit mr, input int lit_state, input int lit_ill);
        ctl_t act;
        @(negedge clk);
        Opcode   = op;
        MemReady = mr;
        #1;
        act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
        chk("ctrl", 32'(act), 32'(expect_ctl(m_state, mr, 1'b0)));
        chk("state", 32'(State), 32'(m_state));
        chk("illegal", 32'(IllegalOp), 32'(m_illegal));
`ifdef MC_RETIRE_CNT_EN
        chk("retire", RetireCount, m_retire);
`endif
        if (lit_state >= 0) chk("state_lit", 32'(State), 32'(lit_state));
        if (lit_ill >= 0) chk("illegal_lit", 32'(IllegalOp), 32'(lit_ill));
        @(posedge clk);
        model_edge(op, mr);
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] instr_op;
        ctl_t       act;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        // Reset state, checked while reset is still asserted.
        rst_n = 1'b0; MemReady = 1'b0; Opcode = 6'd0;
        model_reset();
        #1;
        act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
        chk("reset_ctrl", 32'(act), 32'(expect_ctl(0, 1'b0, 1'b1)));
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_illegal", 32'(IllegalOp), 32'd0);
        #1 rst_n = 1'b1;

        // Fetch stall for three cycles, then R-type.
        for (int i = 0; i < 3; i++) cyc(6'd0, 1'b0, 0, 0);
        cyc(rnd_op(), 1'b1, 0, 0);
        cyc(6'b000000, 1'b1, 1, 0);
        cyc(rnd_op(), 1'b1, 6, 0);
        cyc(rnd_op(), 1'b1, 7, 0);

        // lw with two stall cycles in MEMRD.
        cyc(rnd_op(), 1'b1, 0, 0);
        cyc(6'b100011, 1'b1, 1, 0);
        cyc(6'b100011, 1'b1, 2, 0);
        cyc(rnd_op(), 1'b0, 3, 0);
        cyc(rnd_op(), 1'b0, 3, 0);
        cyc(rnd_op(), 1'b1, 3, 0);
        cyc(rnd_op(), 1'b1, 4, 0);

        // beq then j.
        cyc(rnd_op(), 1'b1, 0, 0);
        cyc(6'b000100, 1'b1, 1, 0);
        cyc(rnd_op(), 1'b1, 8, 0);
        cyc(rnd_op(), 1'b1, 0, 0);
        cyc(6'b000010, 1'b1, 1, 0);
        cyc(rnd_op(), 1'b1, 9, 0);

        // Illegal opcode, then addi with the flag still held.
        cyc(rnd_op(), 1'b1, 0, 0);
        cyc(6'b111111, 1'b1, 1, 0);
        cyc(rnd_op(), 1'b1, 0, 1);
        cyc(6'b001000, 1'b1, 1, 1);
        cyc(rnd_op(), 1'b1, 10, 1);
        cyc(rnd_op(), 1'b1, 11, 1);

        // sw held in MEMWR, then reset asserted mid-cycle with no clock edge.
        cyc(rnd_op(), 1'b1, 0, 1);
        cyc(6'b101011, 1'b1, 1, 1);
        cyc(6'b101011, 1'b1, 2, 1);
        cyc(rnd_op(), 1'b0, 5, 1);
        @(negedge clk);
        MemReady = 1'b0;
        #1;
        chk("memwr_write_lit", 32'(MemWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_memwrite", 32'(MemWrite), 32'd0);
        chk("async_state", 32'(State), 32'd0);
        chk("async_illegal", 32'(IllegalOp), 32'd0);
`ifdef MC_RETIRE_CNT_EN
        chk("async_retire", RetireCount, 32'd0);
`endif
        model_reset();
        #1 rst_n = 1'b1;

        // Randomized instruction stream against the model.
        instr_op = legal_ops[$urandom_range(0, 5)];
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            bit         mr;
            if (m_state == 0) begin
                if ($urandom_range(0, 7) == 0) instr_op = rnd_op();
                else instr_op = legal_ops[$urandom_range(0, 5)];
            end
            op = (m_state == 1 || m_state == 2) ? instr_op : rnd_op();
            mr = ($urandom_range(0, 9) < 7);
            cyc(op, mr, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS main control FSM, directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath mux selects and write enables, plus the 2-bit ALUOp that feeds the ALU control block's UCon input.
- Stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of state register and State debug port (fixed; 12 states used).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26]; valid from DECODE onward.
- MemReady  in  1  memory completes current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU Zero (branch).
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load instruction register.
- MemtoReg  out  1  1 = MDR to register file.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- ALUOp  out  2  to ALU control UCon: 00 add, 01 sub, 10 funct decode.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- IllegalOp  out  1  sticky unsupported-opcode flag.
- State  out  4  current state, for debug.

Behaviour:
- Moore FSM. Outputs decode only the state register, except the MemReady gating listed below. Any output not listed for a state is 0.
- Reset: state = FETCH (0) and IllegalOp = 0, both asynchronously. While rst_n = 0, PCWrite, PCWriteCond, IRWrite, MemWrite, MemRead and RegWrite are forced to 0 combinationally.
- FETCH (0):
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH until MemReady = 1, then goes to DECODE.
- DECODE (1):
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target precompute).
  - Next state by Opcode: 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX.
  - Any other opcode -> FETCH, with IllegalOp set to 1 on that edge.
- MEMADR (2): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: 100011 -> MEMRD, otherwise -> MEMWR.
- MEMRD (3): MemRead = 1, IorD = 1. Waits for MemReady, then -> MEMWB.
- MEMWB (4): RegWrite = 1, MemtoReg = 1, RegDst = 0 -> FETCH.
- MEMWR (5): MemWrite = 1, IorD = 1. Waits for MemReady, then -> FETCH.
- EXEC (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> RTYPEWB.
- RTYPEWB (7): RegDst = 1, RegWrite = 1, MemtoReg = 0 -> FETCH.
- BRANCH (8): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01 -> FETCH.
- JUMP (9): PCWrite = 1, PCSource = 10 -> FETCH.
- ADDIEX (10): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 -> ADDIWB.
- ADDIWB (11): RegDst = 0, RegWrite = 1 -> FETCH.
- Encodings 12-15 are unreachable. If entered, go to FETCH on the next edge with all outputs 0.
- Latency with MemReady held at 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle MemReady is low in a waiting state adds one cycle.
- IllegalOp is cleared only by reset. Further illegal opcodes leave it at 1.
- Opcode changes in states other than DECODE and MEMADR have no effect.

Optional Feature:
- Macro: MC_RETIRE_CNT_EN.
- When defined:
  - Adds output RetireCount (32 bits), reset to 0 asynchronously.
  - Increments by 1 on each edge that leaves MEMWB, MEMWR (with MemReady = 1), RTYPEWB, BRANCH, JUMP or ADDIWB.
  - Wraps from 0xFFFFFFFF to 0.
  - Illegal opcodes are not counted.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then R-type: Opcode = 000000, MemReady = 1 -> State sequence 0,1,6,7,0. ALUOp = 10 only in state 6. RegWrite = 1, RegDst = 1 only in state 7.
- lw with MemReady low for 2 cycles in MEMRD: Opcode = 100011 -> sequence 0,1,2,3,3,3,4,0 (7 cycles). MemtoReg = 1 and RegWrite = 1 in state 4.
- Fetch stall: MemReady = 0 for 3 cycles after reset -> State holds at 0 and IRWrite = PCWrite = 0. On the cycle MemReady = 1, IRWrite = PCWrite = 1, then State = 1.
- beq then j: Opcode = 000100 -> state 8 with ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next, Opcode = 000010 -> state 9 with PCWrite = 1, PCSource = 10.
- Illegal opcode 111111 -> DECODE goes to FETCH, IllegalOp = 1 and stays 1 through a following valid addi (sequence 0,1,10,11,0). Only reset clears it.
- Async reset asserted mid-MEMWR while MemWrite = 1 -> MemWrite = 0 and State = 0 within the same cycle, with no clock edge. Under MC_RETIRE_CNT_EN, RetireCount = 0.
